stopwatch_ctrl: RTL

- Downstream consumer of the 3-digit BCD millisecond counter: takes its once-per-1000-clk wrap pulse (tick) and its BCD value (ms_bcd).
- Accumulates seconds (00-59) and minutes (00-99) in BCD and runs a start/stop/lap state machine.
- Drives the millisecond counter's active-low reset so sub-second time is zeroed while idle or paused.
- Presents live or lap-frozen time to the display stage.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_if.sv | 24 ++
 rtl/stopwatch_ctrl_bcd_digit.sv | 32 +++
 rtl/stopwatch_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and BCD limits for the stopwatch controller and its digit counters.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [7:0] SEC_MAX      = 8'h59;

  function automatic logic is_counting(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle between the ms counter / buttons / display stage and the stopwatch controller.
interface stopwatch_ctrl_if;
  logic        tick;
  logic [11:0] ms_bcd;
  logic        start_stop;
  logic        lap;
  logic        cnt_rst_n;
  logic [7:0]  disp_min;
  logic [7:0]  disp_sec;
  logic [11:0] disp_ms;
  logic        running;
  logic        lap_active;
  logic        overflow;

  modport master (
    output tick, ms_bcd, start_stop, lap,
    input  cnt_rst_n, disp_min, disp_sec, disp_ms, running, lap_active, overflow
  );

  modport slave (
    input  tick, ms_bcd, start_stop, lap,
    output cnt_rst_n, disp_min, disp_sec, disp_ms, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit counting 0..MAX; carry is combinational so digits chain in a single edge.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] d,
  output logic [3:0] d_next,
  output logic       carry
);
  logic [3:0] r_d;

  always_comb begin
    d_next = r_d;
    if (clr)
      d_next = 4'd0;
    else if (inc)
      d_next = (r_d == MAX) ? 4'd0 : r_d + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      r_d <= 4'd0;
    else
      r_d <= d_next;
  end

  assign d     = r_d;
  assign carry = inc && (r_d == MAX);
endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch: BCD sec/min accumulation from ms-counter wrap ticks,
// ms-counter reset control and live/lap-frozen display registers.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter logic [7:0] MIN_MAX_BCD = 8'h99
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);
  state_t      r_state, w_state_next;
  logic        w_clear, w_count;
  logic        w_sec0_carry, w_sec1_carry, w_min0_carry, w_min1_carry;
  logic        w_min_wrap, w_min0_inc;
  logic [3:0]  w_sec0, w_sec1, w_min0, w_min1;
  logic [3:0]  w_sec0_n, w_sec1_n, w_min0_n, w_min1_n;
  logic        r_cnt_rst_n, r_running, r_lap_active, r_overflow;
  logic [7:0]  r_disp_min, r_disp_sec;
  logic [11:0] r_disp_ms;

  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  // start_stop wins over lap in every state
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    case (r_state)
      IDLE:  if (bus.start_stop) w_state_next = RUN;
      RUN:   if (bus.start_stop) w_state_next = PAUSE;
             else if (bus.lap)   w_state_next = LAP;
      LAP:   if (bus.start_stop) w_state_next = PAUSE;
             else if (bus.lap)   w_state_next = RUN;
      PAUSE: if (bus.start_stop) w_state_next = RUN;
             else if (bus.lap) begin
               w_state_next = IDLE;
               w_clear      = 1'b1;
             end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_count    = bus.tick && is_counting(r_state);
  assign w_min_wrap = w_sec1_carry && ({w_min1, w_min0} == MIN_MAX_BCD);
  assign w_min0_inc = w_sec1_carry && !w_min_wrap;

  bcd_digit #(.MAX(DIGIT_MAX)) u_sec0 (
    .clk(clk), .reset(reset), .inc(w_count), .clr(w_clear),
    .d(w_sec0), .d_next(w_sec0_n), .carry(w_sec0_carry)
  );
  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec1 (
    .clk(clk), .reset(reset), .inc(w_sec0_carry), .clr(w_clear),
    .d(w_sec1), .d_next(w_sec1_n), .carry(w_sec1_carry)
  );
  bcd_digit #(.MAX(DIGIT_MAX)) u_min0 (
    .clk(clk), .reset(reset), .inc(w_min0_inc), .clr(w_clear || w_min_wrap),
    .d(w_min0), .d_next(w_min0_n), .carry(w_min0_carry)
  );
  bcd_digit #(.MAX(DIGIT_MAX)) u_min1 (
    .clk(clk), .reset(reset), .inc(w_min0_carry), .clr(w_clear || w_min_wrap),
    .d(w_min1), .d_next(w_min1_n), .carry(w_min1_carry)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt_rst_n  <= 1'b0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_cnt_rst_n  <= is_counting(w_state_next);
      r_running    <= is_counting(w_state_next);
      r_lap_active <= (w_state_next == LAP);
      if (w_clear)
        r_overflow <= 1'b0;
      else if (w_min_wrap)
        r_overflow <= 1'b1;
    end
  end

  // Entering LAP loads the post-tick values once; staying in LAP holds them
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_disp_min <= 8'h00;
      r_disp_sec <= 8'h00;
      r_disp_ms  <= 12'h000;
    end else if (!(r_state == LAP && w_state_next == LAP)) begin
      r_disp_min <= {w_min1_n, w_min0_n};
      r_disp_sec <= {w_sec1_n, w_sec0_n};
      r_disp_ms  <= bus.ms_bcd;
    end
  end

  assign bus.cnt_rst_n  = r_cnt_rst_n;
  assign bus.running    = r_running;
  assign bus.lap_active = r_lap_active;
  assign bus.overflow   = r_overflow;
  assign bus.disp_min   = r_disp_min;
  assign bus.disp_sec   = r_disp_sec;
  assign bus.disp_ms    = r_disp_ms;
endmodule
